// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial engine.
package fact_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StMul,
    StDec,
    StDone
  } fact_state_e;

  localparam int unsigned FACT_W   = 64;
  localparam int unsigned DONE_BIT = 0;
  localparam int unsigned INTR_BIT = 1;

endpackage

// File: rtl/factorial_core_if.sv
// Register-block side of the factorial engine: control bits in, status and result out.
interface factorial_core_if #(
  parameter int unsigned WIDTH = 64
);
  logic             op_start;
  logic             op_clear;
  logic             intr_en;
  logic [WIDTH-1:0] operand;
  logic [1:0]       op_done;
  logic [WIDTH-1:0] result_h;
  logic [WIDTH-1:0] result_l;
  logic             interrupt;

  modport master (
    output op_start, op_clear, intr_en, operand,
    input  op_done, result_h, result_l, interrupt
  );

  modport slave (
    input  op_start, op_clear, intr_en, operand,
    output op_done, result_h, result_l, interrupt
  );
endinterface

// File: rtl/fact_shift_add_mul.sv
// 2W x W shift-add multiplier, one partial product per cycle.
// FACT_EARLY_EXIT_EN: stop as soon as the remaining multiplier bits are all zero.
module fact_shift_add_mul #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               start,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               last_step;

  always_comb begin
`ifdef FACT_EARLY_EXIT_EN
    last_step = (cnt_q == LastCnt) || ((mplier_q >> 1) == '0);
`else
    last_step = (cnt_q == LastCnt);
`endif
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (clear) begin
      mcand_d  = '0;
      mplier_d = '0;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b0;
    end else if (start) begin
      mcand_d  = mcand;
      mplier_d = mplier;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      busy_d   = ~last_step;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // Combinational so the sequencer leaves MUL on the same edge as the final step.
  assign done    = busy_q & last_step;
  assign busy    = busy_q;
  assign product = prod_q;

endmodule

// File: rtl/factorial_core.sv
// Iterative factorial sequencer: acc = n * (n-1) * ... * 2 modulo 2^(2*WIDTH).
// Multiplier loop length depends on FACT_EARLY_EXIT_EN (see fact_shift_add_mul).
module factorial_core
  import fact_pkg::*;
#(
  parameter int unsigned WIDTH = FACT_W
) (
  input logic             clk,
  input logic             reset_n,
  factorial_core_if.slave bus
);
  localparam int unsigned      AccW   = 2 * WIDTH;
  localparam logic [AccW-1:0]  AccOne = {{(AccW - 1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] NOne   = {{(WIDTH - 1){1'b0}}, 1'b1};

  fact_state_e      state_q, state_d;
  logic [AccW-1:0]  acc_q, acc_d, result_q, result_d;
  logic [WIDTH-1:0] n_q, n_d, n_dec;
  logic             done_q, done_d;
  logic             mul_start, mul_busy, mul_done;
  logic [AccW-1:0]  mul_mcand, mul_prod;
  logic [WIDTH-1:0] mul_mplier;
  logic [1:0]       op_done;

  assign n_dec = n_q - NOne;

  fact_shift_add_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (bus.op_clear),
    .start  (mul_start),
    .mcand  (mul_mcand),
    .mplier (mul_mplier),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_prod)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    n_d        = n_q;
    done_d     = done_q;
    result_d   = result_q;
    mul_start  = 1'b0;
    mul_mcand  = '0;
    mul_mplier = '0;
    case (state_q)
      StIdle: if (bus.op_start) state_d = StInit;
      StInit: begin
        acc_d = AccOne;
        n_d   = bus.operand;
        if (bus.operand <= NOne) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = AccOne;
        end else begin
          state_d    = StMul;
          mul_start  = 1'b1;
          mul_mcand  = AccOne;
          mul_mplier = bus.operand;
        end
      end
      StMul: if (mul_done) state_d = StDec;
      StDec: begin
        acc_d = mul_prod;
        n_d   = n_dec;
        if (n_dec == NOne) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = mul_prod;
        end else begin
          state_d    = StMul;
          mul_start  = 1'b1;
          mul_mcand  = mul_prod;
          mul_mplier = n_dec;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
    // Clear wins over everything, including a start seen in the same cycle.
    if (bus.op_clear) begin
      state_d   = StIdle;
      acc_d     = '0;
      n_d       = '0;
      done_d    = 1'b0;
      result_d  = '0;
      mul_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      n_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      n_q      <= n_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  mul_busy_in_mul: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == StMul) |-> mul_busy);

  always_comb begin
    op_done           = '0;
    op_done[DONE_BIT] = done_q;
    op_done[INTR_BIT] = done_q & bus.intr_en;
  end

  assign bus.op_done   = op_done;
  assign bus.interrupt = op_done[INTR_BIT];
  assign bus.result_h  = result_q[AccW-1:WIDTH];
  assign bus.result_l  = result_q[WIDTH-1:0];

endmodule

// File: tb/tb_factorial_core.sv
// Self-checking bench for factorial_core; expected products queued at start, checked at done.
module tb_factorial_core;
  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic reset_n;
  int   check_cnt = 0;
  int   pass_cnt = 0;
  logic [2*W-1:0] sb_q[$];

  factorial_core_if #(.WIDTH(W)) bus ();

  factorial_core #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] fact_model(input longint unsigned n);
    logic [2*W-1:0] r;
    r = 1;
    for (longint unsigned i = 2; i <= n; i++) r = r * (2*W)'(i);
    return r;
  endfunction

  function automatic int mul_len(input longint unsigned m);
`ifdef FACT_EARLY_EXIT_EN
    int b;
    longint unsigned v;
    b = 0;
    v = m;
    while (v != 0) begin
      b++;
      v = v >> 1;
    end
    return (b == 0) ? 1 : b;
`else
    return W;
`endif
  endfunction

  function automatic int exp_latency(input longint unsigned n);
    int l;
    if (n <= 1) return 1;
    l = 1;
    for (longint unsigned m = n; m >= 2; m--) l += mul_len(m) + 1;
    return l;
  endfunction

  task automatic run_op(input logic [W-1:0] n, input logic [2*W-1:0] expv, input string tag,
                        input int change_at, input logic [W-1:0] new_op);
    int             k, lat;
    logic           quiet;
    logic [2*W-1:0] exp_res;
    lat = exp_latency(n);
    sb_q.push_back(expv);
    @(negedge clk);
    bus.operand  = n;
    bus.op_start = 1'b1;
    @(posedge clk);
    #1;
    bus.op_start = 1'b0;
    k = 0;
    quiet = 1'b1;
    while (k < lat + 8) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.op_done[0]) break;
      if (k == change_at) bus.operand = new_op;
      if (bus.op_done !== 2'b00 || bus.interrupt !== 1'b0 || bus.result_h !== '0 ||
          bus.result_l !== '0) quiet = 1'b0;
    end
    check_cnt++;
    if (k !== lat) $display("FAIL %s latency: got %0d expected %0d", tag, k, lat);
    else pass_cnt++;
    check_cnt++;
    if (quiet !== 1'b1) $display("FAIL %s outputs_zero_while_busy: got %b expected 1", tag, quiet);
    else pass_cnt++;
    exp_res = sb_q.pop_front();
    check_cnt++;
    if ({bus.result_h, bus.result_l} !== exp_res)
      $display("FAIL %s result: got %h_%h expected %h", tag, bus.result_h, bus.result_l, exp_res);
    else pass_cnt++;
    check_cnt++;
    if (bus.op_done !== {bus.intr_en, 1'b1} || bus.interrupt !== bus.intr_en)
      $display("FAIL %s status: got op_done=%b irq=%b expected op_done=%b irq=%b", tag,
               bus.op_done, bus.interrupt, {bus.intr_en, 1'b1}, bus.intr_en);
    else pass_cnt++;
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    bus.op_clear = 1'b1;
    @(posedge clk);
    #1;
    check_cnt++;
    if ({bus.op_done, bus.interrupt, bus.result_h, bus.result_l} !== '0)
      $display("FAIL %s clear: got op_done=%b irq=%b res=%h_%h expected all 0", tag, bus.op_done,
               bus.interrupt, bus.result_h, bus.result_l);
    else pass_cnt++;
    @(negedge clk);
    bus.op_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;
    bus.intr_en  = 1'b0;
    bus.operand  = '0;
    #22;
    check_cnt++;
    if ({bus.op_done, bus.interrupt, bus.result_h, bus.result_l} !== '0)
      $display("FAIL reset_values: got op_done=%b irq=%b res=%h_%h expected all 0", bus.op_done,
               bus.interrupt, bus.result_h, bus.result_l);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if (bus.op_done !== 2'b00) $display("FAIL idle_after_reset: got %b expected 00", bus.op_done);
    else pass_cnt++;
  endtask

  task automatic test_small();
    bus.intr_en = 1'b0;
    run_op(64'd0, fact_model(0), "n0", -1, '0);
    do_clear("n0");
    run_op(64'd1, fact_model(1), "n1", -1, '0);
    do_clear("n1");
  endtask

  task automatic test_five();
    bus.intr_en = 1'b0;
    run_op(64'd5, 128'd120, "n5", -1, '0);
    do_clear("n5");
  endtask

  task automatic test_intr_toggle();
    bus.intr_en = 1'b1;
    run_op(64'd21, {64'h2, 64'hC5077D36B8C40000}, "n21", -1, '0);
    @(negedge clk);
    bus.intr_en = 1'b0;
    #1;
    check_cnt++;
    if (bus.op_done !== 2'b01 || bus.interrupt !== 1'b0)
      $display("FAIL intr_off: got op_done=%b irq=%b expected 01/0", bus.op_done, bus.interrupt);
    else pass_cnt++;
    bus.intr_en = 1'b1;
    #1;
    check_cnt++;
    if (bus.op_done !== 2'b11 || bus.interrupt !== 1'b1)
      $display("FAIL intr_on: got op_done=%b irq=%b expected 11/1", bus.op_done, bus.interrupt);
    else pass_cnt++;
    do_clear("n21");
    bus.intr_en = 1'b0;
  endtask

  task automatic test_operand_change();
    run_op(64'd20, {64'h0, 64'h21C3677C82B40000}, "n20_opchg", 3, 64'd3);
    do_clear("n20");
  endtask

  task automatic test_clear_mid();
    @(negedge clk);
    bus.operand  = 64'd10;
    bus.op_start = 1'b1;
    @(posedge clk);
    #1;
    bus.op_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.op_clear = 1'b1;
    bus.op_start = 1'b1;
    @(posedge clk);
    #1;
    check_cnt++;
    if ({bus.op_done, bus.interrupt, bus.result_h, bus.result_l} !== '0)
      $display("FAIL clear_mid_mul: got op_done=%b res=%h_%h expected all 0", bus.op_done,
               bus.result_h, bus.result_l);
    else pass_cnt++;
    @(negedge clk);
    bus.op_clear = 1'b0;
    bus.op_start = 1'b0;
    run_op(64'd4, 128'd24, "n4_after_clear", -1, '0);
    do_clear("n4");
  endtask

  task automatic test_reset_mid_dec();
    @(negedge clk);
    bus.operand  = 64'd5;
    bus.op_start = 1'b1;
    @(posedge clk);
    #1;
    bus.op_start = 1'b0;
    repeat (1 + mul_len(5)) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_cnt++;
    if ({bus.op_done, bus.interrupt, bus.result_h, bus.result_l} !== '0)
      $display("FAIL reset_mid_dec: got op_done=%b res=%h_%h expected all 0", bus.op_done,
               bus.result_h, bus.result_l);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    run_op(64'd3, 128'd6, "n3_after_reset", -1, '0);
    do_clear("n3");
  endtask

  task automatic test_hold_start();
    logic held_ok;
    bus.intr_en = 1'b0;
    run_op(64'd6, 128'd720, "n6", -1, '0);
    @(negedge clk);
    bus.op_start = 1'b1;
    held_ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.op_done !== 2'b01 || bus.result_l !== 64'd720 || bus.result_h !== '0)
        held_ok = 1'b0;
    end
    check_cnt++;
    if (held_ok !== 1'b1) $display("FAIL start_held_in_done: got %b expected 1", held_ok);
    else pass_cnt++;
    bus.op_start = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_cnt++;
    if ({bus.op_done, bus.interrupt, bus.result_h, bus.result_l} !== '0)
      $display("FAIL async_reset_in_done: got op_done=%b res=%h_%h expected all 0", bus.op_done,
               bus.result_h, bus.result_l);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    longint unsigned ops[6] = '{2, 3, 7, 12, 34, 35};
    bus.intr_en = 1'b1;
    foreach (ops[i]) begin
      run_op(W'(ops[i]), fact_model(ops[i]), $sformatf("b2b_n%0d", ops[i]), -1, '0);
      do_clear("b2b");
    end
    bus.intr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_small();
    test_five();
    test_intr_toggle();
    test_operand_change();
    test_clear_mid();
    test_reset_mid_dec();
    test_hold_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/factorial_core.md
Name: factorial_core

Overview:
- Compute engine fed by the memory-mapped factorial register block.
- Consumes the operation start, clear and interrupt-enable bits plus the 64-bit operand from that block.
- Computes operand! iteratively, using a multi-cycle shift-add multiplier and a 2*WIDTH-bit accumulator.
- Returns to the register block the 2-bit done/status code, the high and low result words, and a level interrupt.

Parameters:
- WIDTH, 64, operand width; result is 2*WIDTH bits, split into result_h and result_l.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- op_start  in  1  level start request, bit 0 of the start register
- op_clear  in  1  synchronous clear, bit 0 of the clear register
- intr_en  in  1  interrupt enable
- operand  in  WIDTH  n, the value whose factorial is computed
- op_done  out  2  bit0 = result done; bit1 = interrupt pending, i.e. intr_en & done
- result_h  out  WIDTH  result bits [2W-1:W]
- result_l  out  WIDTH  result bits [W-1:0]
- interrupt  out  1  level, equals op_done[1]

Behaviour:
- Clock and reset: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: state IDLE; op_done=0, result_h=0, result_l=0, interrupt=0; all internal registers 0.
- States:
  - IDLE: op_start=1 -> INIT.
  - INIT: acc=1, n=operand (latched here). If n<=1 -> DONE; else -> MUL.
  - MUL: one shift-add step per cycle. If mplier[0], prod += mcand. Then mcand<<=1, mplier>>=1. mcand = acc, mplier = n. Exactly WIDTH cycles, then -> DEC.
  - DEC: acc=prod (truncated to 2W bits), n=n-1. If n-1==1 -> DONE; else -> MUL.
  - DONE: result_h/result_l = acc; op_done[0]=1. Holds until op_clear.
- Latency: op_done[0] rises on edge k after the edge that samples op_start.
  - n<=1: k=1.
  - n>=2: k = 1 + (n-1)*(WIDTH+1).
  - WIDTH=64, n=5: k=261.
- Result outputs read 0 in IDLE, INIT, MUL and DEC; they are only valid in DONE.
- Arithmetic is modulo 2^(2W). n>34 (WIDTH=64) wraps silently; no error flag.
- operand changes after INIT are ignored.
- op_start held high in DONE does not restart; a restart requires op_clear and then op_start.
- op_clear=1 in any state, next edge: state IDLE, all outputs and registers 0. op_clear has priority over op_start in the same cycle. The block stays in IDLE while op_clear=1.
- intr_en is combinational into op_done[1] and interrupt, so toggling it in DONE immediately changes both.
- reset_n asserted mid-operation aborts immediately to the reset values.

Optional Feature:
- FACT_EARLY_EXIT_EN defined: MUL ends once the shifted mplier becomes 0 after a step. MUL length = bit length of the current n (minimum 1). Results are identical.
  - n=5: k = 1 + (3+1) + (3+1) + (2+1) + (2+1) = 15.
- Undefined: fixed WIDTH-cycle MUL as specified above.

Decomposition:
- Package fact_pkg:
  - state enum: IDLE, INIT, MUL, DEC, DONE
  - localparam FACT_W default 64
  - op_done bit index constants: DONE_BIT=0, INTR_BIT=1
- Sub-module fact_shift_add_mul: 2W x W shift-add multiplier.
  - Inputs: start, mcand, mplier.
  - Outputs: busy, done pulse, product.
  - Contains the step counter and the early-exit logic.
- factorial_core keeps the sequencer FSM, the n counter and the output registers.

Test Plan:
- operand=0 and operand=1, op_start=1 -> op_done=2'b01 one edge after sampling; result_h=0, result_l=1.
- operand=5, intr_en=0 -> result_l=120, result_h=0. op_done[0] at edge 261 (15 with FACT_EARLY_EXIT_EN); interrupt stays 0.
- operand=21, intr_en=1 -> result_h=0x2, result_l=0xC5077D36B8C40000; op_done=2'b11 and interrupt=1. Then intr_en=0 -> op_done=2'b01, interrupt=0.
- operand=20 -> result_l=0x21C3677C82B40000, result_h=0. Changing operand to 3 mid-MUL does not alter the result.
- op_clear pulsed mid-MUL for operand=10 -> next edge outputs 0 and state IDLE. A subsequent op_start with operand=4 yields 24.
- reset_n low during DEC -> all outputs 0 asynchronously. op_start held in DONE -> no recompute, op_done stays 1.
